// File: rtl/rsqrt_fp_pkg.sv
// Shared definitions for the float32 reciprocal-square-root wrapper:
// operand classes, float32 field layout, special encodings and the
// 1/sqrt(2) constant used for odd exponents.
package rsqrt_fp_pkg;

  localparam int FP_W     = 32;
  localparam int FRAC_W   = 23;
  localparam int EXP_W    = 8;
  localparam int EXP_LSB  = 23;
  localparam int SIGN_BIT = 31;

  localparam int          BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;
  localparam logic [31:0] NINF = 32'hFF800000;

  // 1/sqrt(2) in 0.24 unsigned fixed point
  localparam logic [23:0] INV_SQRT2 = 24'hB504F3;

  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_ZERO   = 3'd1,
    CLS_NEG    = 3'd2,
    CLS_NAN    = 3'd3,
    CLS_INF    = 3'd4
  } fp_class_t;

  // Per-operand sideband carried alongside the core pipeline
  typedef struct packed {
    logic              valid;
    logic signed [7:0] k;
    logic              r;
    fp_class_t         cls;
    logic              sign;
  } sideband_t;

  localparam int SB_W = $bits(sideband_t);

  // Denormals fall into CLS_ZERO (flush to zero); -inf is treated as a
  // negative operand.
  function automatic fp_class_t classify(input logic [31:0] f);
    logic [7:0]  ex;
    logic [22:0] fr;
    ex = f[EXP_LSB +: EXP_W];
    fr = f[FRAC_W-1:0];
    if (ex == 8'd0)
      return CLS_ZERO;
    if (ex == 8'hFF) begin
      if (fr != 23'd0)
        return CLS_NAN;
      return f[SIGN_BIT] ? CLS_NEG : CLS_INF;
    end
    if (f[SIGN_BIT])
      return CLS_NEG;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/rsqrt_sideband_delay.sv
// CE-gated shift register that carries the sideband word in step with the
// mantissa core. Synchronous active-low clear empties every stage.
module rsqrt_sideband_delay #(
  parameter int W     = 14,
  parameter int DEPTH = 6
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         CE,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [W-1:0] data_reg;
      if (gi == 0) begin : g_first
        // first stage captures the freshly unpacked sideband
        always_ff @(posedge CLK) begin
          if (!nRST)
            data_reg <= '0;
          else if (CE)
            data_reg <= din;
        end
      end else begin : g_next
        // later stages advance one step per enabled cycle
        always_ff @(posedge CLK) begin
          if (!nRST)
            data_reg <= '0;
          else if (CE)
            data_reg <= g_stage[gi-1].data_reg;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].data_reg;

endmodule

// File: rtl/rsqrt_fp32_wrap.sv
// Float32 front/back end around the mantissa rsqrt core. The front end
// unpacks the operand and drives the core; the sideband (exponent half,
// parity, class, sign) rides a matched delay line; P1 applies 1/sqrt(2)
// for odd exponents, P2 normalises, rounds to nearest even and packs.
module rsqrt_fp32_wrap #(
  parameter int             CORE_LAT  = 6,
  parameter int             WLM       = 24,
  parameter logic [WLM-1:0] INV_SQRT2 = rsqrt_fp_pkg::INV_SQRT2
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           CE,
  input  logic           in_valid,
  input  logic [31:0]    in_float,
  output logic [WLM-1:0] core_din,
  output logic           core_ce,
  input  logic [WLM-1:0] core_dout,
  output logic           out_valid,
  output logic [31:0]    out_float,
  output logic           flag_invalid,
  output logic           flag_divzero
);
  import rsqrt_fp_pkg::*;

  // Product is 2.(PW-2): bit ONE_BIT is the units position
  localparam int PW      = 2 * WLM;
  localparam int ONE_BIT = PW - 2;
  localparam int SIG_LSB = ONE_BIT - FRAC_W;

  logic signed [8:0]  e_unb;
  sideband_t          sb_in, sb_out, p1_sb_reg;
  logic [SB_W-1:0]    sb_out_w;
  logic [PW-1:0]      prod_next, p1_prod_reg;

  logic               is_one, guard, sticky, round_up;
  logic [PW-1:0]      norm;
  logic [23:0]        sig;
  logic [24:0]        sig_rnd;
  logic signed [9:0]  k_ext, exp_b;
  logic [31:0]        res_next;
  logic               inv_next, dz_next;
  logic               out_valid_reg, flag_invalid_reg, flag_divzero_reg;
  logic [31:0]        out_float_reg;
  logic               unused_bits;

  assign core_din = {1'b1, in_float[FRAC_W-1:0]};
  assign core_ce  = CE;

  // Unbiased exponent; k = floor(e/2) via arithmetic shift, r = e & 1
  assign e_unb = $signed({1'b0, in_float[EXP_LSB +: EXP_W]}) - 9'sd127;

  // unpack the operand into its sideband word
  always_comb begin
    sb_in       = '0;
    sb_in.valid = in_valid;
    sb_in.k     = 8'(e_unb >>> 1);
    sb_in.r     = e_unb[0];
    sb_in.cls   = classify(in_float);
    sb_in.sign  = in_float[SIGN_BIT];
  end

  rsqrt_sideband_delay #(
    .W     (SB_W),
    .DEPTH (CORE_LAT)
  ) u_sideband_delay (
    .CLK  (CLK),
    .nRST (nRST),
    .CE   (CE),
    .din  (sb_in),
    .dout (sb_out_w)
  );

  assign sb_out = sideband_t'(sb_out_w);

  // odd exponents fold the leftover sqrt(2) into the mantissa
  always_comb begin
    prod_next = '0;
    if (sb_out.r)
      prod_next = PW'(core_dout) * PW'(INV_SQRT2);
    else
      prod_next = {core_dout, {WLM{1'b0}}};
  end

  // P1 register: scaled mantissa plus its sideband
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      p1_sb_reg   <= '0;
      p1_prod_reg <= '0;
    end else if (CE) begin
      p1_sb_reg   <= sb_out;
      p1_prod_reg <= prod_next;
    end
  end

  // normalise into [1,2), round to nearest even, pack; specials override
  always_comb begin
    is_one   = p1_prod_reg[ONE_BIT];
    norm     = is_one ? p1_prod_reg : (p1_prod_reg << 1);
    sig      = norm[ONE_BIT -: 24];
    guard    = norm[SIG_LSB-1];
    sticky   = |norm[SIG_LSB-2:0];
    round_up = guard & (sticky | sig[0]);
    sig_rnd  = {1'b0, sig} + {24'd0, round_up};
    k_ext    = {{2{p1_sb_reg.k[7]}}, p1_sb_reg.k};
    exp_b    = 10'sd127 - k_ext;
    if (!is_one)
      exp_b = exp_b - 10'sd1;
    // a rounding carry leaves the fraction zero and bumps the exponent
    if (sig_rnd[24])
      exp_b = exp_b + 10'sd1;
    res_next = {1'b0, exp_b[7:0], sig_rnd[22:0]};
    inv_next = 1'b0;
    dz_next  = 1'b0;
    case (p1_sb_reg.cls)
      CLS_ZERO: begin
        res_next = p1_sb_reg.sign ? NINF : PINF;
        dz_next  = 1'b1;
      end
      CLS_INF: begin
        res_next = 32'd0;
      end
      CLS_NEG, CLS_NAN: begin
        res_next = QNAN;
        inv_next = 1'b1;
      end
      default: ;
    endcase
  end

  // P2 register: packed result and flags, held while CE is low
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      out_valid_reg    <= 1'b0;
      out_float_reg    <= 32'd0;
      flag_invalid_reg <= 1'b0;
      flag_divzero_reg <= 1'b0;
    end else if (CE) begin
      out_valid_reg    <= p1_sb_reg.valid;
      out_float_reg    <= res_next;
      flag_invalid_reg <= inv_next;
      flag_divzero_reg <= dz_next;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_float    = out_float_reg;
  assign flag_invalid = flag_invalid_reg;
  assign flag_divzero = flag_divzero_reg;

  // bits that are structurally dead after normalisation
  assign unused_bits = ^{norm[PW-1], sig_rnd[23], exp_b[9:8], p1_sb_reg.r};

endmodule

// File: tb/tb_rsqrt_fp32_wrap.sv
// Scoreboard bench for rsqrt_fp32_wrap with a behavioural mantissa core.
module tb_rsqrt_fp32_wrap;
  localparam int CORE_LAT = 6;
  localparam int WLM      = 24;

  logic           CLK = 1'b0;
  logic           nRST = 1'b0;
  logic           CE = 1'b1;
  logic           in_valid = 1'b0;
  logic [31:0]    in_float = 32'd0;
  logic [WLM-1:0] core_din, core_dout;
  logic           core_ce;
  logic           out_valid, flag_invalid, flag_divzero;
  logic [31:0]    out_float;

  always #5 CLK = ~CLK;

  rsqrt_fp32_wrap #(.CORE_LAT(CORE_LAT), .WLM(WLM)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .CE           (CE),
    .in_valid     (in_valid),
    .in_float     (in_float),
    .core_din     (core_din),
    .core_ce      (core_ce),
    .core_dout    (core_dout),
    .out_valid    (out_valid),
    .out_float    (out_float),
    .flag_invalid (flag_invalid),
    .flag_divzero (flag_divzero)
  );

  int n_checks  = 0;
  int fails     = 0;
  int n_applied = 0;

  // Behavioural core: 1/sqrt(m), m in [1,2) as 1.23, result 2.22 rounded
  function automatic logic [WLM-1:0] core_rsqrt(input logic [WLM-1:0] din);
    real m;
    m = real'(din) / 8388608.0;
    return WLM'($rtoi(4194304.0 / $sqrt(m) + 0.5));
  endfunction

  logic [WLM-1:0] core_pipe [CORE_LAT];
  always @(posedge CLK) begin
    if (core_ce) begin
      core_pipe[0] <= core_rsqrt(core_din);
      for (int i = 1; i < CORE_LAT; i++)
        core_pipe[i] <= core_pipe[i-1];
    end
  end
  assign core_dout = core_pipe[CORE_LAT-1];

  // Reference: classify, then 1/sqrt(x) = core(m) * 2^(-e/2) in real maths
  task automatic model(input logic [31:0] op, output logic [31:0] bits,
                       output bit exact, output real refv,
                       output bit inv, output bit dz);
    int  ex, e, k;
    real cd;
    ex = int'(op[30:23]);
    bits = 32'd0; exact = 1'b1; refv = 0.0; inv = 1'b0; dz = 1'b0;
    if (ex == 0) begin
      bits = op[31] ? 32'hFF800000 : 32'h7F800000;
      dz   = 1'b1;
    end else if (ex == 255 && op[22:0] != 23'd0) begin
      bits = 32'h7FC00000; inv = 1'b1;
    end else if (op[31]) begin
      bits = 32'h7FC00000; inv = 1'b1;
    end else if (ex == 255) begin
      bits = 32'd0;
    end else begin
      exact = 1'b0;
      e  = ex - 127;
      k  = int'($floor(e / 2.0));
      cd = real'(core_rsqrt({1'b1, op[22:0]})) / 4194304.0;
      if (e - 2 * k == 1)
        cd = cd / $sqrt(2.0);
      refv = cd * $pow(2.0, real'(-k));
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  task automatic check_ulp(input logic [31:0] act, input real refv);
    int  dexp;
    real dval, ulp;
    dexp = int'(act[30:23]);
    ulp  = $pow(2.0, real'(dexp - 150));
    dval = real'({1'b1, act[22:0]}) * ulp;
    n_checks++;
    if (act[31] || dexp == 0 || dexp == 255 || (dval - refv) > ulp || (refv - dval) > ulp) begin
      fails++;
      $display("FAIL rsqrt_ulp: got %08h (%g), required within 1 ulp of %g", act, dval, refv);
    end
  endtask

  // Scoreboard queues, filled whenever an operand is actually captured
  logic [31:0] q_op[$];
  int          q_tag[$];
  bit          q_has[$];
  logic [31:0] q_want[$];
  int          edge_cnt = 0;
  bit          ce_last = 1'b0;
  bit          dir_has = 1'b0;
  logic [31:0] dir_want = 32'd0;

  always @(posedge CLK) begin
    ce_last <= CE;
    if (!nRST) begin
      q_op.delete(); q_tag.delete(); q_has.delete(); q_want.delete();
    end else if (CE) begin
      if (in_valid) begin
        q_op.push_back(in_float);
        q_tag.push_back(edge_cnt);
        q_has.push_back(dir_has);
        q_want.push_back(dir_want);
        n_applied <= n_applied + 1;
      end
      edge_cnt <= edge_cnt + 1;
    end
  end

  logic [31:0] mon_op, mon_want, m_bits;
  int          mon_tag;
  bit          mon_has, m_exact, m_inv, m_dz;
  real         m_ref;

  // Monitor: a new result exists when the previous edge was enabled
  always @(negedge CLK) begin
    if (nRST) begin
      check32("core_ce", {31'd0, core_ce}, {31'd0, CE});
      if (in_valid)
        check32("core_din", {8'd0, core_din}, {9'd1, in_float[22:0]});
    end
    if (nRST && ce_last && out_valid) begin
      if (q_op.size() == 0) begin
        n_checks++;
        fails++;
        $display("FAIL unexpected_output: got out_float=%08h, required no output", out_float);
      end else begin
        mon_op   = q_op.pop_front();
        mon_tag  = q_tag.pop_front();
        mon_has  = q_has.pop_front();
        mon_want = q_want.pop_front();
        model(mon_op, m_bits, m_exact, m_ref, m_inv, m_dz);
        check32("latency", 32'(edge_cnt - mon_tag), 32'(CORE_LAT + 2));
        check32("flag_invalid", {31'd0, flag_invalid}, {31'd0, m_inv});
        check32("flag_divzero", {31'd0, flag_divzero}, {31'd0, m_dz});
        if (m_exact)
          check32("special_result", out_float, m_bits);
        else
          check_ulp(out_float, m_ref);
        if (mon_has)
          check32("directed_result", out_float, mon_want);
        $display("txn op=%08h out=%08h inv=%0b dz=%0b", mon_op, out_float, flag_invalid, flag_divzero);
      end
    end
  end

  task automatic issue(input logic [31:0] op, input bit has_want, input logic [31:0] want);
    in_valid = 1'b1;
    in_float = op;
    dir_has  = has_want;
    dir_want = want;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    dir_has  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q_op.size() != 0; i++)
      @(posedge CLK);
    #1;
    n_checks++;
    if (q_op.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", q_op.size());
    end
  endtask

  logic [31:0] dir_ops  [10] = '{32'h3F800000, 32'h40800000, 32'h40000000, 32'h7F000000, 32'h00800000,
                                 32'h00000000, 32'h80000000, 32'h7F800000, 32'hBF800000, 32'h7FC12345};
  logic [31:0] dir_outs [10] = '{32'h3F800000, 32'h3F000000, 32'h3F3504F3, 32'h1FB504F3, 32'h5F000000,
                                 32'h7F800000, 32'hFF800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000};

  initial begin
    int cnt;
    logic [31:0] op;
    nRST = 1'b0; CE = 1'b1; in_valid = 1'b0; in_float = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    check32("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check32("reset_out_float", out_float, 32'd0);
    check32("reset_flag_invalid", {31'd0, flag_invalid}, 32'd0);
    check32("reset_flag_divzero", {31'd0, flag_divzero}, 32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Directed normals, then specials back to back
    for (int i = 0; i < 5; i++) begin
      issue(dir_ops[i], 1'b1, dir_outs[i]);
      wait_drain();
    end
    for (int i = 5; i < 10; i++)
      issue(dir_ops[i], 1'b1, dir_outs[i]);
    wait_drain();

    // Random positive normals with random CE stalls and gaps
    cnt = 0;
    while (cnt < 1000) begin
      op       = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      CE       = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 7) != 0);
      in_float = op;
      if (CE && in_valid) cnt++;
      @(posedge CLK); #1;
    end
    CE = 1'b1; in_valid = 1'b0;
    wait_drain();

    // Reset with three operands in flight
    for (int i = 0; i < 3; i++)
      issue({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)}, 1'b0, 32'd0);
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    for (int i = 0; i < CORE_LAT + 2; i++) begin
      @(posedge CLK); #1;
      check32("post_reset_quiet", {31'd0, out_valid}, 32'd0);
    end
    issue(32'h3F800000, 1'b1, 32'h3F800000);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
